// File: rtl/interrupt_scheduler_pkg.sv
// Shared definitions for the interrupt scheduler.
// Holds the one-hot FSM state encodings, which follow the RX engine style,
// and the bit positions of the interrupt cause register.
package interrupt_scheduler_pkg;

  typedef enum logic [7:0] {
    ST_IDLE    = 8'b0000_0001,
    ST_ASSERT  = 8'b0000_0010,
    ST_HOLDOFF = 8'b0000_0100
  } int_state_t;

  // int_cause bit positions
  localparam int unsigned CAUSE_RX = 0;
  localparam int unsigned CAUSE_TX = 1;

endpackage

// File: rtl/interrupt_scheduler_holdoff_timer.sv
// holdoff_timer: down-counter that enforces the minimum gap between
// consecutive interrupt assertions.
// Ports:
//   trn_clk  - clock (rising edge)
//   reset    - synchronous active-high reset, clears the count
//   load     - load load_val (takes priority over en)
//   load_val - value to load
//   en       - decrement by one per cycle, saturating at zero
//   zero     - count currently reads zero
module holdoff_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    zero = (cnt == '0);
  end

endmodule

// File: rtl/interrupt_scheduler.sv
// interrupt_scheduler: coalesces RX/TX events into legacy PCIe interrupt
// requests, enforces a holdoff between grants and keeps a cause register
// and a grant counter for the host.
// Ports:
//   trn_clk             - clock (rising edge)
//   reset               - synchronous active-high reset
//   interrupts_enabled  - host interrupt enable (level)
//   rx_event            - one-cycle pulse per received packet
//   tx_event            - one-cycle pulse per transmit completion
//   cause_clr           - one-cycle pulse, host has read int_cause
//   cfg_interrupt_n     - active-low interrupt request to the PCIe core
//   cfg_interrupt_rdy_n - active-low grant from the PCIe core
//   int_cause           - latched cause, bit0 rx, bit1 tx
//   int_count           - number of granted interrupts, wraps
module interrupt_scheduler
  import interrupt_scheduler_pkg::*;
#(
  parameter logic [15:0] HOLDOFF_CYCLES = 16'd1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic        interrupts_enabled,
  input  logic        rx_event,
  input  logic        tx_event,
  input  logic        cause_clr,
  output logic        cfg_interrupt_n,
  input  logic        cfg_interrupt_rdy_n,
  output logic [1:0]  int_cause,
  output logic [15:0] int_count
);

  // A holdoff of zero cycles behaves like one cycle.
  localparam logic [15:0]      HOLDOFF_M1 = (HOLDOFF_CYCLES == 16'd0) ? 16'd0
                                                                      : HOLDOFF_CYCLES - 16'd1;
  localparam logic [CNT_W-1:0] LOAD_VAL   = CNT_W'(HOLDOFF_M1);

  int_state_t state;
  logic       rx_pend;
  logic       tx_pend;
  logic       grant;
  logic       tmr_en;
  logic       tmr_zero;
  logic       wake;
  logic [1:0] pend_vec;
  logic [1:0] cause_base;

  always_comb begin
    grant               = (state == ST_ASSERT) && !cfg_interrupt_rdy_n;
    tmr_en              = (state == ST_HOLDOFF);
    pend_vec            = '0;
    pend_vec[CAUSE_RX]  = rx_pend;
    pend_vec[CAUSE_TX]  = tx_pend;
    cause_base          = cause_clr ? '0 : int_cause;
    // The incoming pulse is included so the request rises in the cycle right
    // after the event, the same cycle the pending bit becomes visible.
    wake                = (rx_pend || tx_pend || rx_event || tx_event) && interrupts_enabled;
  end

  holdoff_timer #(
    .CNT_W (CNT_W)
  ) u_holdoff_timer (
    .trn_clk  (trn_clk),
    .reset    (reset),
    .load     (grant),
    .load_val (LOAD_VAL),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cfg_interrupt_n <= 1'b1;
      int_cause       <= '0;
      int_count       <= '0;
      rx_pend         <= 1'b0;
      tx_pend         <= 1'b0;
    end else begin
      // A new event wins over the clear caused by a grant in the same cycle.
      rx_pend <= rx_event || (rx_pend && !grant);
      tx_pend <= tx_event || (tx_pend && !grant);

      if (cause_clr) begin
        int_cause <= '0;
      end

      unique case (state)
        ST_IDLE: begin
          if (wake) begin
            state           <= ST_ASSERT;
            cfg_interrupt_n <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (grant) begin
            int_cause       <= cause_base | pend_vec;
            int_count       <= int_count + 16'd1;
            state           <= ST_HOLDOFF;
            cfg_interrupt_n <= 1'b1;
          end else if (!interrupts_enabled) begin
            state           <= ST_IDLE;
            cfg_interrupt_n <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (tmr_zero) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state           <= ST_IDLE;
          cfg_interrupt_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Directed scoreboard bench for interrupt_scheduler (HOLDOFF_CYCLES = 8).
module tb_interrupt_scheduler;

  logic        trn_clk = 1'b0;
  logic        reset;
  logic        interrupts_enabled;
  logic        rx_event;
  logic        tx_event;
  logic        cause_clr;
  logic        cfg_interrupt_n;
  logic        cfg_interrupt_rdy_n;
  logic [1:0]  int_cause;
  logic [15:0] int_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic [1:0]  cause;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];

  always #5 trn_clk = ~trn_clk;

  interrupt_scheduler #(
    .HOLDOFF_CYCLES (16'd8),
    .CNT_W          (16)
  ) dut (
    .trn_clk             (trn_clk),
    .reset               (reset),
    .interrupts_enabled  (interrupts_enabled),
    .rx_event            (rx_event),
    .tx_event            (tx_event),
    .cause_clr           (cause_clr),
    .cfg_interrupt_n     (cfg_interrupt_n),
    .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n),
    .int_cause           (int_cause),
    .int_count           (int_count)
  );

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for the request to go low; n = ticks waited.
  task automatic wait_assert(input string name, input int max_cycles, output int n);
    n = 0;
    while (cfg_interrupt_n !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    total++;
    if (cfg_interrupt_n !== 1'b0) begin
      bad++;
      $display("FAIL %s: no assertion within %0d cycles, cfg_interrupt_n=%b", name, max_cycles, cfg_interrupt_n);
    end
  endtask

  task automatic hold_high(input string name, input int n);
    logic seen_low;
    seen_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cfg_interrupt_n !== 1'b1) seen_low = 1'b1;
    end
    check1(name, {31'd0, seen_low}, 32'd0);
  endtask

  // Grants the pending request; expected cause/count go to the scoreboard.
  task automatic do_grant(input logic [1:0] ec, input logic [15:0] ecnt,
                          input logic with_rx, input logic with_clr);
    exp_t e;
    e.cause = ec;
    e.count = ecnt;
    exp_q.push_back(e);
    cfg_interrupt_rdy_n = 1'b0;
    rx_event            = with_rx;
    cause_clr           = with_clr;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
    rx_event            = 1'b0;
    cause_clr           = 1'b0;
    check1("deassert_after_grant", {31'd0, cfg_interrupt_n}, 32'd1);
  endtask

  task automatic clear_cause();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check1("cause_clr", {30'd0, int_cause}, 32'd0);
  endtask

  // Monitor: every grant handshake is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge trn_clk);
      if (reset === 1'b0 && cfg_interrupt_n === 1'b0 && cfg_interrupt_rdy_n === 1'b0) begin
        @(posedge trn_clk);
        #2;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: cause=%b count=%0d", int_cause, int_count);
        end else begin
          e = exp_q.pop_front();
          check1("grant_cause", {30'd0, int_cause}, {30'd0, e.cause});
          check1("grant_count", {16'd0, int_count}, {16'd0, e.count});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset               = 1'b1;
    interrupts_enabled  = 1'b0;
    rx_event            = 1'b0;
    tx_event            = 1'b0;
    cause_clr           = 1'b0;
    cfg_interrupt_rdy_n = 1'b1;
    repeat (3) tick();
    check1("reset_cfg_n",  {31'd0, cfg_interrupt_n}, 32'd1);
    check1("reset_cause",  {30'd0, int_cause},       32'd0);
    check1("reset_count",  {16'd0, int_count},       32'd0);
    reset              = 1'b0;
    interrupts_enabled = 1'b1;
    tick();

    // Single event: low for four cycles, then granted.
    rx_event = 1'b1;
    tick();
    rx_event = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("single_low", {31'd0, cfg_interrupt_n}, 32'd0);
      tick();
    end
    check1("single_low", {31'd0, cfg_interrupt_n}, 32'd0);
    do_grant(2'b01, 16'd1, 1'b0, 1'b0);

    // Coalescing during holdoff.
    clear_cause();
    for (int i = 0; i < 5; i++) begin
      rx_event = 1'b1;
      tx_event = (i < 3);
      tick();
      rx_event = 1'b0;
      tx_event = 1'b0;
      check1("holdoff_quiet", {31'd0, cfg_interrupt_n}, 32'd1);
    end
    wait_assert("coalesce_assert", 10, n);
    check1("holdoff_length", n, 32'd3);
    do_grant(2'b11, 16'd2, 1'b0, 1'b0);
    hold_high("single_assert_only", 20);
    clear_cause();

    // Disabled: events accumulate, assert once enabled.
    interrupts_enabled = 1'b0;
    tx_event = 1'b1;
    tick();
    tx_event = 1'b0;
    hold_high("disabled_quiet", 20);
    interrupts_enabled = 1'b1;
    tick();
    check1("enable_assert", {31'd0, cfg_interrupt_n}, 32'd0);
    do_grant(2'b10, 16'd3, 1'b0, 1'b0);
    hold_high("s3_holdoff", 12);
    clear_cause();

    // Enable drop while waiting for a grant.
    rx_event = 1'b1;
    tick();
    rx_event = 1'b0;
    check1("drop_pre_low", {31'd0, cfg_interrupt_n}, 32'd0);
    tick();
    tick();
    interrupts_enabled = 1'b0;
    tick();
    check1("enable_drop_high", {31'd0, cfg_interrupt_n}, 32'd1);
    hold_high("drop_quiet", 3);
    interrupts_enabled = 1'b1;
    tick();
    check1("reenable_assert", {31'd0, cfg_interrupt_n}, 32'd0);
    do_grant(2'b01, 16'd4, 1'b0, 1'b0);
    hold_high("s4_holdoff", 12);
    clear_cause();

    // Event in the grant cycle stays pending; then clear coincident with grant.
    tx_event = 1'b1;
    tick();
    tx_event = 1'b0;
    check1("collide_pre_low", {31'd0, cfg_interrupt_n}, 32'd0);
    do_grant(2'b10, 16'd5, 1'b1, 1'b0);
    wait_assert("collision_reassert", 15, n);
    check1("collision_holdoff_len", n, 32'd9);
    do_grant(2'b01, 16'd6, 1'b0, 1'b1);
    hold_high("s5_holdoff", 12);

    // Reset mid-ASSERT.
    rx_event = 1'b1;
    tick();
    rx_event = 1'b0;
    check1("rst_pre_low", {31'd0, cfg_interrupt_n}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("rst_cfg_n", {31'd0, cfg_interrupt_n}, 32'd1);
    check1("rst_count", {16'd0, int_count},       32'd0);
    check1("rst_cause", {30'd0, int_cause},       32'd0);
    hold_high("post_reset_quiet", 30);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected grants not seen", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
